// File: rtl/reg_pipeline.sv
// reg_pipeline: elastic DEPTH-stage, WIDTH-bit register pipeline with valid/ready handshakes
// at both ends. Empty stages always accept, so bubbles collapse towards the output.
// Occupancy is reported as a registered count.
//
// Optional feature: define REG_PIPELINE_FLUSH_EN to enable the synchronous flush. When it is
// undefined, the flush port is present but ignored.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset; clears all stages
//   in_data    write data
//   in_valid   in_data is valid this cycle
//   in_ready   pipeline accepts in_data this cycle (combinational from out_ready)
//   out_data   data held by the last stage
//   out_valid  last stage holds a valid word
//   out_ready  consumer takes out_data this cycle
//   flush      discard all held words (only with REG_PIPELINE_FLUSH_EN)
//   count      number of occupied stages (registered)
`timescale 1ns/1ps
module reg_pipeline #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CntW = $clog2(DEPTH + 1);
  typedef logic [CntW-1:0] cnt_t;

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            full_q, full_d;
  logic [DEPTH-1:0]            adv;
  cnt_t                        count_q, count_d;
  logic                        flush_act;

`ifdef REG_PIPELINE_FLUSH_EN
  assign flush_act = flush;
`else
  logic unused_flush;
  assign unused_flush = flush;
  assign flush_act    = 1'b0;
`endif

  // Move chain, evaluated from the output end backwards: a stage may move if it is empty or
  // its downstream neighbour is moving.
  always_comb begin
    adv          = '0;
    adv[DEPTH-1] = (out_ready & ~flush_act) | ~full_q[DEPTH-1];
    for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
      adv[i] = adv[i+1] | ~full_q[i];
    end
  end

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (flush_act) begin
      // Drop every held word. Data is left untouched so only the valid bits change.
      full_d = '0;
    end else begin
      if (adv[0]) begin
        full_d[0] = in_valid;
        if (in_valid) begin
          data_d[0] = in_data;
        end
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (adv[i]) begin
          full_d[i] = full_q[i-1];
          // A bubble moving in leaves the old data in place.
          if (full_q[i-1]) begin
            data_d[i] = data_q[i-1];
          end
        end
      end
    end
    count_d = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      count_d = count_d + cnt_t'(full_d[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q  <= '0;
      full_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      full_q  <= full_d;
      count_q <= count_d;
    end
  end

  assign in_ready  = adv[0] & ~flush_act;
  assign out_data  = data_q[DEPTH-1];
  assign out_valid = full_q[DEPTH-1] & ~flush_act;
  assign count     = count_q;

endmodule

// File: tb/tb_reg_pipeline.sv
`timescale 1ns/1ps
module tb_reg_pipeline;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       flush;

  // DEPTH=2 instance, checked through the scoreboard
  logic [7:0] in_data, out_data;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [1:0] count;

  // DEPTH=4 instance, used for the bubble-collapse case
  logic [7:0] in_data4, out_data4;
  logic       in_valid4, in_ready4, out_valid4, out_ready4;
  logic [2:0] count4;

  reg_pipeline #(.WIDTH(8), .DEPTH(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .flush     (flush),
    .count     (count)
  );

  reg_pipeline #(.WIDTH(8), .DEPTH(4)) dut4 (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data4),
    .in_valid  (in_valid4),
    .in_ready  (in_ready4),
    .out_data  (out_data4),
    .out_valid (out_valid4),
    .out_ready (out_ready4),
    .flush     (flush),
    .count     (count4)
  );

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_w;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every output transfer must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL sb_unexpected: got %0h expected no word", out_data);
      end else begin
        exp_w = sb.pop_front();
        chk("sb_data", {24'h0, out_data}, {24'h0, exp_w});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; flush = 1'b0;
    in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
    in_data4 = '0; in_valid4 = 1'b0; out_ready4 = 1'b0;
    step();
    step();
    rst = 1'b0;

    // Reset state
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_count4", 32'(count4), 0);

    // Streaming 0x11, 0x22, 0x33 with out_ready high
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 8'h11;
    #1;
    chk("stream_in_ready", 32'(in_ready), 1);
    sb.push_back(8'h11);
    step();
    chk("stream_lat_e1_valid", 32'(out_valid), 0);
    chk("stream_count_e1", 32'(count), 1);
    in_data = 8'h22;
    sb.push_back(8'h22);
    step();
    chk("stream_lat_e2_valid", 32'(out_valid), 1);
    chk("stream_count_e2", 32'(count), 2);
    in_data = 8'h33;
    sb.push_back(8'h33);
    step();
    chk("stream_count_e3", 32'(count), 2);
    in_valid = 1'b0;
    step();
    step();
    chk("stream_drained_count", 32'(count), 0);
    chk("stream_drained_valid", 32'(out_valid), 0);

    // Back-pressure: two accepts fill the pipe, third word is held off
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hA1;
    sb.push_back(8'hA1);
    step();
    in_data = 8'hA2;
    sb.push_back(8'hA2);
    step();
    in_data = 8'hA3;
    #1;
    chk("bp_in_ready_full", 32'(in_ready), 0);
    chk("bp_count_full", 32'(count), 2);
    step();
    step();
    chk("bp_count_hold", 32'(count), 2);
    chk("bp_out_data_hold", 32'(out_data), 32'hA1);
    chk("bp_in_ready_hold", 32'(in_ready), 0);
    out_ready = 1'b1;
    #1;
    chk("bp_in_ready_release", 32'(in_ready), 1);
    sb.push_back(8'hA3);
    step();
    chk("bp_count_after_swap", 32'(count), 2);

    // Full pass-through: one in and one out on the same edge
    in_data = 8'hB1;
    #1;
    chk("pass_in_ready_full", 32'(in_ready), 1);
    sb.push_back(8'hB1);
    step();
    chk("pass_count", 32'(count), 2);
    in_valid = 1'b0;
    step();
    step();
    step();
    chk("pass_drained_count", 32'(count), 0);

    // Flush with two words held
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hC1;
    sb.push_back(8'hC1);
    step();
    in_data = 8'hC2;
    sb.push_back(8'hC2);
    step();
    chk("flush_pre_count", 32'(count), 2);
    flush   = 1'b1;
    in_data = 8'hC3;
    #1;
`ifdef REG_PIPELINE_FLUSH_EN
    chk("flush_out_valid", 32'(out_valid), 0);
    chk("flush_in_ready", 32'(in_ready), 0);
`else
    chk("noflush_out_valid", 32'(out_valid), 1);
    chk("noflush_in_ready", 32'(in_ready), 0);
`endif
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    #1;
`ifdef REG_PIPELINE_FLUSH_EN
    chk("flush_count", 32'(count), 0);
    chk("flush_post_valid", 32'(out_valid), 0);
    chk("flush_data_hold", 32'(out_data), 32'hC1);
    sb.delete();
`else
    chk("noflush_count", 32'(count), 2);
    chk("noflush_post_valid", 32'(out_valid), 1);
`endif
    out_ready = 1'b1;
    step();
    step();
    step();
    chk("flush_drained_count", 32'(count), 0);

    // Reset mid-stream discards the held word
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 8'hD1;
    step();
    in_valid = 1'b0;
    chk("midrst_pre_count", 32'(count), 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("midrst_count", 32'(count), 0);
    chk("midrst_out_valid", 32'(out_valid), 0);
    out_ready = 1'b1;

    // Bubble collapse on DEPTH=4 with out_ready low
    in_valid4 = 1'b1;
    in_data4  = 8'h5C;
    #1;
    chk("bub_in_ready_e0", 32'(in_ready4), 1);
    step();
    in_valid4 = 1'b0;
    chk("bub_count_e1", 32'(count4), 1);
    chk("bub_valid_e1", 32'(out_valid4), 0);
    chk("bub_in_ready_e1", 32'(in_ready4), 1);
    step();
    step();
    chk("bub_valid_e3", 32'(out_valid4), 0);
    chk("bub_count_e3", 32'(count4), 1);
    step();
    chk("bub_valid_e4", 32'(out_valid4), 1);
    chk("bub_data_e4", 32'(out_data4), 32'h5C);
    chk("bub_count_e4", 32'(count4), 1);
    chk("bub_in_ready_e4", 32'(in_ready4), 1);

    step();
    chk("sb_empty", 32'(sb.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
